// File: rtl/rocket_mass_ratio_div.sv
// Mass-ratio stage: latches post-burn weight and computes mu = after*SCALE/initial
// with a 32-step restoring divider, handing the result off over valid/ready.
module rocket_mass_ratio_div #(
  parameter int unsigned SCALE = 1_000_000_000,
  parameter int          ITER  = 32
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [31:0] initialWeight,
  input  logic [31:0] propellentWeight,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] afterWeight,
  output logic [31:0] mu,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [31:0]   n_lo;

  logic [31:0] diff_w;
  logic [63:0] prod;
  logic        bad;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nxt;

  assign diff_w = initialWeight - propellentWeight;
  assign prod   = {32'd0, diff_w} * {32'd0, SCALE};
  assign bad    = (initialWeight == 32'd0) || (propellentWeight > initialWeight);

  // N < D*2^32, so the upper half of N is already a valid partial remainder;
  // only the low 32 bits need to be shifted through the divider.
  assign trial   = {rem, n_lo[31]};
  assign ge      = trial >= {1'b0, dvs};
  assign rem_nxt = ge ? (trial[31:0] - dvs) : trial[31:0];

  always_ff @(posedge clk) begin
    if (resetb) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      n_lo        <= '0;
      afterWeight <= '0;
      mu          <= '0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (bad) begin
              err         <= 1'b1;
              mu          <= '0;
              afterWeight <= '0;
              state       <= DONE;
            end else begin
              err         <= 1'b0;
              afterWeight <= diff_w;
              rem         <= prod[63:32];
              n_lo        <= prod[31:0];
              quo         <= '0;
              dvs         <= initialWeight;
              cnt         <= CW'(ITER - 1);
              state       <= DIV;
            end
          end
        end
        DIV: begin
          rem  <= rem_nxt;
          n_lo <= {n_lo[30:0], 1'b0};
          quo  <= {quo[30:0], ge};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            mu        <= {quo[30:0], ge};
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Error path enters DONE straight from accept; valid follows one edge later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
